// File: rtl/buzzer_pkg.sv
// buzzer_pkg: shared constants for the buzzer melody sequencer.
//   - note frequencies (octave 4, do..si) and the half_period() helper
//   - note-table entry field layout
//   - sequencer FSM state encoding
package buzzer_pkg;

    localparam int unsigned NOTE_HZ_DO = 262;
    localparam int unsigned NOTE_HZ_RE = 294;
    localparam int unsigned NOTE_HZ_MI = 330;
    localparam int unsigned NOTE_HZ_FA = 349;
    localparam int unsigned NOTE_HZ_SO = 392;
    localparam int unsigned NOTE_HZ_LA = 440;
    localparam int unsigned NOTE_HZ_SI = 494;

    // Entry layout: [15:12] note, [11:10] octave shift, [9:0] duration (ticks)
    localparam int unsigned ENTRY_W = 16;
    localparam int unsigned NOTE_LSB = 12;
    localparam int unsigned NOTE_W   = 4;
    localparam int unsigned OCT_LSB  = 10;
    localparam int unsigned OCT_W    = 2;
    localparam int unsigned DUR_LSB  = 0;
    localparam int unsigned DUR_W    = 10;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        CHECK = 2'd2,
        PLAY  = 2'd3
    } state_e;

    // Clock cycles per half period of an octave-4 note; 0 for rests.
    function automatic int unsigned half_period(input int unsigned clk_hz,
                                                input int unsigned note);
        int unsigned f;
        case (note)
            1:       f = NOTE_HZ_DO;
            2:       f = NOTE_HZ_RE;
            3:       f = NOTE_HZ_MI;
            4:       f = NOTE_HZ_FA;
            5:       f = NOTE_HZ_SO;
            6:       f = NOTE_HZ_LA;
            7:       f = NOTE_HZ_SI;
            default: f = 0;
        endcase
        return (f == 0) ? 0 : clk_hz / (2 * f);
    endfunction

endpackage

// File: rtl/buzzer_tone_gen.sv
// buzzer_tone_gen: square-wave generator with a programmable half period.
//   clk, reset_p : clock, synchronous active-high reset
//   clear        : restart the half-period count and drive the wave low
//   enable       : 0 forces the output low and holds the counter at 0
//   half         : half period in clock cycles (must be >= 1 while enabled)
//   wave         : square-wave output
module buzzer_tone_gen #(
    parameter int unsigned HALF_W = 18
) (
    input  logic              clk,
    input  logic              reset_p,
    input  logic              clear,
    input  logic              enable,
    input  logic [HALF_W-1:0] half,
    output logic              wave
);

    logic [HALF_W-1:0] cnt_q;
    logic              out_q;

    always_ff @(posedge clk) begin
        if (reset_p || clear || !enable) begin
            cnt_q <= '0;
            out_q <= 1'b0;
        end else if (cnt_q == half - HALF_W'(1)) begin
            cnt_q <= '0;
            out_q <= ~out_q;
        end else begin
            cnt_q <= cnt_q + HALF_W'(1);
        end
    end

    // Gate with enable so the pin drops in the same cycle the FSM leaves PLAY.
    assign wave = out_q & enable;

endmodule

// File: rtl/buzzer_sequencer.sv
// buzzer_sequencer: plays a writable table of (note, octave, duration)
// entries as a square wave on buzzer_out.
//   clk, reset_p       : clock, synchronous active-high reset
//   wr_en/addr/data    : note-table write port (legal at any time)
//   start              : one-cycle pulse, begins playback at address 0
//   stop               : abort playback (highest priority)
//   loop               : sampled at end of song; 1 restarts at address 0
//   busy               : high while not IDLE
//   note_addr          : address of the entry being fetched or played
//   buzzer_out         : square-wave output
module buzzer_sequencer
    import buzzer_pkg::*;
#(
    parameter int unsigned sys_clk_freq = 100_000_000,
    parameter int unsigned DEPTH        = 16,
    parameter int unsigned TICK_HZ      = 100
) (
    input  logic                     clk,
    input  logic                     reset_p,
    input  logic                     wr_en,
    input  logic [$clog2(DEPTH)-1:0] wr_addr,
    input  logic [15:0]              wr_data,
    input  logic                     start,
    input  logic                     stop,
    input  logic                     loop,
    output logic                     busy,
    output logic [$clog2(DEPTH)-1:0] note_addr,
    output logic                     buzzer_out
);

    localparam int unsigned AW       = $clog2(DEPTH);
    localparam int unsigned TICK_CYC = sys_clk_freq / TICK_HZ;
    localparam int unsigned TICK_W   = $clog2(TICK_CYC + 1);
    localparam int unsigned HALF_W   = $clog2(half_period(sys_clk_freq, 1) + 1);

    localparam logic [HALF_W-1:0] HALF1 = HALF_W'(half_period(sys_clk_freq, 1));
    localparam logic [HALF_W-1:0] HALF2 = HALF_W'(half_period(sys_clk_freq, 2));
    localparam logic [HALF_W-1:0] HALF3 = HALF_W'(half_period(sys_clk_freq, 3));
    localparam logic [HALF_W-1:0] HALF4 = HALF_W'(half_period(sys_clk_freq, 4));
    localparam logic [HALF_W-1:0] HALF5 = HALF_W'(half_period(sys_clk_freq, 5));
    localparam logic [HALF_W-1:0] HALF6 = HALF_W'(half_period(sys_clk_freq, 6));
    localparam logic [HALF_W-1:0] HALF7 = HALF_W'(half_period(sys_clk_freq, 7));

    logic [ENTRY_W-1:0] mem [DEPTH];

    state_e              state_q, state_d;
    logic [AW-1:0]       addr_q, addr_d;
    logic [ENTRY_W-1:0]  rd_q;
    logic [TICK_W-1:0]   tick_q, tick_d;
    logic [DUR_W-1:0]    dur_q, dur_d;
    logic [NOTE_W-1:0]   note_q, note_d;
    logic [OCT_W-1:0]    oct_q, oct_d;
    logic                tone_clr;
    logic                tone_en;
    logic [HALF_W-1:0]   half_base;
    logic [HALF_W-1:0]   half;

    wire [DUR_W-1:0]  rd_dur  = rd_q[DUR_LSB +: DUR_W];
    wire [NOTE_W-1:0] rd_note = rd_q[NOTE_LSB +: NOTE_W];
    wire [OCT_W-1:0]  rd_oct  = rd_q[OCT_LSB +: OCT_W];

    // Table: no reset, so contents survive reset_p.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_addr] <= wr_data;
    end

    always_ff @(posedge clk) begin
        if (reset_p) begin
            state_q <= IDLE;
            addr_q  <= '0;
            rd_q    <= '0;
            tick_q  <= '0;
            dur_q   <= '0;
            note_q  <= '0;
            oct_q   <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            tick_q  <= tick_d;
            dur_q   <= dur_d;
            note_q  <= note_d;
            oct_q   <= oct_d;
            if (state_q == FETCH) rd_q <= mem[addr_q];
        end
    end

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        tick_d   = tick_q;
        dur_d    = dur_q;
        note_d   = note_q;
        oct_d    = oct_q;
        tone_clr = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = FETCH;
                    addr_d  = '0;
                end
            end
            FETCH: state_d = CHECK;
            CHECK: begin
                if (rd_dur == '0) begin
                    // A marker at address 0 never loops: an empty song would spin.
                    state_d = (loop && addr_q != '0) ? FETCH : IDLE;
                    addr_d  = '0;
                end else begin
                    dur_d    = rd_dur;
                    note_d   = rd_note;
                    oct_d    = rd_oct;
                    tick_d   = '0;
                    tone_clr = 1'b1;
                    state_d  = PLAY;
                end
            end
            PLAY: begin
                if (tick_q == TICK_W'(TICK_CYC - 1)) begin
                    tick_d = '0;
                    if (dur_q == DUR_W'(1)) begin
                        if (addr_q == AW'(DEPTH - 1)) begin
                            addr_d  = '0;
                            state_d = loop ? FETCH : IDLE;
                        end else begin
                            addr_d  = addr_q + AW'(1);
                            state_d = FETCH;
                        end
                    end else begin
                        dur_d = dur_q - DUR_W'(1);
                    end
                end else begin
                    tick_d = tick_q + TICK_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
        if (stop) begin
            state_d = IDLE;
            addr_d  = '0;
            tick_d  = '0;
            dur_d   = '0;
        end
    end

    always_comb begin
        case (note_q)
            4'd1:    half_base = HALF1;
            4'd2:    half_base = HALF2;
            4'd3:    half_base = HALF3;
            4'd4:    half_base = HALF4;
            4'd5:    half_base = HALF5;
            4'd6:    half_base = HALF6;
            4'd7:    half_base = HALF7;
            default: half_base = '0;
        endcase
    end

    assign half    = half_base >> oct_q;
    assign tone_en = (state_q == PLAY) && (note_q != '0) && (note_q <= 4'd7);

    buzzer_tone_gen #(.HALF_W(HALF_W)) u_tone (
        .clk     (clk),
        .reset_p (reset_p),
        .clear   (tone_clr),
        .enable  (tone_en),
        .half    (half),
        .wave    (buzzer_out)
    );

    assign busy      = (state_q != IDLE);
    assign note_addr = addr_q;

endmodule

// File: tb/tb_buzzer_sequencer.sv
module tb_buzzer_sequencer;

    logic        clk = 1'b0;
    logic        reset_p, wr_en, start, stop, loop;
    logic [1:0]  wr_addr, note_addr;
    logic [15:0] wr_data;
    logic        busy, buzzer_out;

    int checks = 0;
    int errors = 0;
    int pc = 0;

    always #5 clk = ~clk;

    buzzer_sequencer #(.sys_clk_freq(1_000_000), .DEPTH(4), .TICK_HZ(1000)) dut (
        .clk(clk), .reset_p(reset_p), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_data(wr_data), .start(start), .stop(stop), .loop(loop),
        .busy(busy), .note_addr(note_addr), .buzzer_out(buzzer_out)
    );

    function automatic logic [15:0] mk(input int n, input int o, input int d);
        return {4'(n), 2'(o), 10'(d)};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic adv_to(input int t);
        while (pc < t) begin
            step();
            pc++;
        end
    endtask

    task automatic wr(input int a, input logic [15:0] d);
        wr_en = 1'b1; wr_addr = 2'(a); wr_data = d;
        step();
        pc++;
        wr_en = 1'b0;
    endtask

    // Pulse start and land on the first PLAY cycle (pc = 0).
    task automatic go_play();
        start = 1'b1; step(); start = 1'b0;
        step(); step();
        pc = 0;
    endtask

    task automatic test_reset();
        reset_p = 1'b1; step(); step(); step();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b exp 0", busy); end
        checks++; if (note_addr !== 2'd0) begin errors++; $display("FAIL reset_addr: got %0d exp 0", note_addr); end
        checks++; if (buzzer_out !== 1'b0) begin errors++; $display("FAIL reset_buz: got %b exp 0", buzzer_out); end
        reset_p = 1'b0; step();
    endtask

    task automatic test_basic();
        wr(0, mk(1, 0, 3)); wr(1, mk(0, 0, 2)); wr(2, 16'h0000);
        start = 1'b1; step(); start = 1'b0;
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL basic_busy_t1: got %b exp 1", busy); end
        step();
        checks++; if (buzzer_out !== 1'b0) begin errors++; $display("FAIL basic_check_buz: got %b exp 0", buzzer_out); end
        step(); pc = 0;
        adv_to(1907);
        checks++; if (buzzer_out !== 1'b0) begin errors++; $display("FAIL basic_pre_toggle: got %b exp 0", buzzer_out); end
        adv_to(1908);
        checks++; if (buzzer_out !== 1'b1) begin errors++; $display("FAIL basic_toggle: got %b exp 1", buzzer_out); end
        adv_to(2999);
        checks++; if (buzzer_out !== 1'b1 || note_addr !== 2'd0) begin errors++; $display("FAIL basic_note_end: got buz=%b addr=%0d exp buz=1 addr=0", buzzer_out, note_addr); end
        adv_to(3000);
        checks++; if (busy !== 1'b1 || buzzer_out !== 1'b0 || note_addr !== 2'd1) begin errors++; $display("FAIL basic_gap: got busy=%b buz=%b addr=%0d exp 1 0 1", busy, buzzer_out, note_addr); end
        adv_to(5001);
        checks++; if (busy !== 1'b1 || buzzer_out !== 1'b0) begin errors++; $display("FAIL basic_rest: got busy=%b buz=%b exp 1 0", busy, buzzer_out); end
        adv_to(5002);
        checks++; if (note_addr !== 2'd2) begin errors++; $display("FAIL basic_fetch2: got %0d exp 2", note_addr); end
        adv_to(5004);
        checks++; if (busy !== 1'b0 || note_addr !== 2'd0) begin errors++; $display("FAIL basic_idle: got busy=%b addr=%0d exp 0 0", busy, note_addr); end
    endtask

    task automatic test_octave();
        wr(0, mk(6, 1, 5)); wr(1, 16'h0000);
        go_play();
        adv_to(567);
        checks++; if (buzzer_out !== 1'b0) begin errors++; $display("FAIL oct1_567: got %b exp 0", buzzer_out); end
        adv_to(568);
        checks++; if (buzzer_out !== 1'b1) begin errors++; $display("FAIL oct1_568: got %b exp 1", buzzer_out); end
        adv_to(1135);
        checks++; if (buzzer_out !== 1'b1) begin errors++; $display("FAIL oct1_1135: got %b exp 1", buzzer_out); end
        adv_to(1136);
        checks++; if (buzzer_out !== 1'b0) begin errors++; $display("FAIL oct1_1136: got %b exp 0", buzzer_out); end
        adv_to(4999);
        checks++; if (busy !== 1'b1 || note_addr !== 2'd0) begin errors++; $display("FAIL oct1_len: got busy=%b addr=%0d exp 1 0", busy, note_addr); end
        adv_to(5000);
        checks++; if (note_addr !== 2'd1) begin errors++; $display("FAIL oct1_next: got %0d exp 1", note_addr); end
        adv_to(5002);
        wr(0, mk(6, 3, 1));
        go_play();
        adv_to(141);
        checks++; if (buzzer_out !== 1'b0) begin errors++; $display("FAIL oct3_141: got %b exp 0", buzzer_out); end
        adv_to(142);
        checks++; if (buzzer_out !== 1'b1) begin errors++; $display("FAIL oct3_142: got %b exp 1", buzzer_out); end
        adv_to(284);
        checks++; if (buzzer_out !== 1'b0) begin errors++; $display("FAIL oct3_284: got %b exp 0", buzzer_out); end
        adv_to(1002);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL oct3_idle: got %b exp 0", busy); end
    endtask

    task automatic test_full_table();
        for (int i = 0; i < 4; i++) wr(i, mk(7, 3, 1));
        loop = 1'b0;
        go_play();
        adv_to(1132);
        checks++; if (buzzer_out !== 1'b1 || note_addr !== 2'd1) begin errors++; $display("FAIL full_n1: got buz=%b addr=%0d exp 1 1", buzzer_out, note_addr); end
        adv_to(4005);
        checks++; if (busy !== 1'b1 || note_addr !== 2'd3) begin errors++; $display("FAIL full_last: got busy=%b addr=%0d exp 1 3", busy, note_addr); end
        adv_to(4006);
        checks++; if (busy !== 1'b0 || note_addr !== 2'd0) begin errors++; $display("FAIL full_noloop_idle: got busy=%b addr=%0d exp 0 0", busy, note_addr); end
        adv_to(4007);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL full_nofetch: got %b exp 0", busy); end
        loop = 1'b1;
        go_play();
        adv_to(4006);
        checks++; if (busy !== 1'b1 || note_addr !== 2'd0) begin errors++; $display("FAIL loop_wrap: got busy=%b addr=%0d exp 1 0", busy, note_addr); end
        adv_to(4138);
        checks++; if (buzzer_out !== 1'b1 || note_addr !== 2'd0) begin errors++; $display("FAIL loop_play: got buz=%b addr=%0d exp 1 0", buzzer_out, note_addr); end
        stop = 1'b1; step(); stop = 1'b0;
        checks++; if (busy !== 1'b0 || buzzer_out !== 1'b0 || note_addr !== 2'd0) begin errors++; $display("FAIL stop_play: got busy=%b buz=%b addr=%0d exp 0 0 0", busy, buzzer_out, note_addr); end
        loop = 1'b0;
    endtask

    task automatic test_empty_loop();
        wr(0, 16'h0000);
        loop = 1'b1;
        start = 1'b1; step(); start = 1'b0;
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL empty_fetch: got %b exp 1", busy); end
        step();
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL empty_check: got %b exp 1", busy); end
        step();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL empty_idle: got %b exp 0", busy); end
        step();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL empty_nospin: got %b exp 0", busy); end
        loop = 1'b0;
    endtask

    task automatic test_start_stop_idle();
        start = 1'b1; stop = 1'b1; step(); start = 1'b0; stop = 1'b0;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL startstop_idle: got %b exp 0", busy); end
        step();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL startstop_idle2: got %b exp 0", busy); end
    endtask

    task automatic test_start_during_play();
        wr(0, mk(7, 3, 1)); wr(1, mk(7, 3, 1)); wr(2, 16'h0000);
        go_play();
        adv_to(500);
        start = 1'b1; step(); pc++; start = 1'b0;
        checks++; if (busy !== 1'b1 || note_addr !== 2'd0) begin errors++; $display("FAIL restart_ignored: got busy=%b addr=%0d exp 1 0", busy, note_addr); end
        adv_to(1000);
        checks++; if (note_addr !== 2'd1) begin errors++; $display("FAIL restart_advance: got %0d exp 1", note_addr); end
        adv_to(2004);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL restart_idle: got %b exp 0", busy); end
    endtask

    task automatic test_rewrite_reset();
        wr(0, mk(1, 0, 1)); wr(1, mk(0, 0, 1)); wr(2, 16'h0000);
        go_play();
        adv_to(200);
        wr(1, mk(6, 3, 1));
        adv_to(1143);
        checks++; if (buzzer_out !== 1'b0 || note_addr !== 2'd1) begin errors++; $display("FAIL rewrite_pre: got buz=%b addr=%0d exp 0 1", buzzer_out, note_addr); end
        adv_to(1144);
        checks++; if (buzzer_out !== 1'b1) begin errors++; $display("FAIL rewrite_new_note: got %b exp 1", buzzer_out); end
        reset_p = 1'b1; step(); reset_p = 1'b0;
        checks++; if (busy !== 1'b0 || buzzer_out !== 1'b0 || note_addr !== 2'd0) begin errors++; $display("FAIL midnote_reset: got busy=%b buz=%b addr=%0d exp 0 0 0", busy, buzzer_out, note_addr); end
        step();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL post_reset_idle: got %b exp 0", busy); end
    endtask

    initial begin
        reset_p = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        start = 1'b0; stop = 1'b0; loop = 1'b0;
        test_reset();
        test_basic();
        test_octave();
        test_full_table();
        test_empty_loop();
        test_start_stop_idle();
        test_start_during_play();
        test_rewrite_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
